// File: rtl/vend_coin_payer.sv
// vend_coin_payer: customer-side coin initiator for a price-PRICE Mealy vending FSM.
// Latency: first coin appears the cycle after an accepted start; one coin per DRIVE
// cycle, GAP_CYCLES idle cycles between coins; done pulses one cycle after the last DRIVE.
// Backpressure: none; start is ignored while busy or in the done cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, n5, n10, mode     load purse (Rs.5 / Rs.10 counts) and coin order, begin paying
//   dispense, chg5           Mealy outputs of the vending FSM, sampled in DRIVE cycles only
//   coin                     01 = Rs.5, 10 = Rs.10, 00 = idle (registered)
//   busy, done               transaction in progress / 1-cycle completion pulse
//   err, paid, coins_used,   outcome of the last transaction, held until the next start
//   chg_rx
//
// Optional feature: define COIN_PAYER_CHG_CHECK_EN to check chg5 against the expected
// change (err=11 on mismatch, or on chg5 without dispense).
module vend_coin_payer #(
  parameter int PRICE      = 20,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n5,
  input  logic [3:0] n10,
  input  logic       mode,
  input  logic       dispense,
  input  logic       chg5,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [6:0] paid,
  output logic [4:0] coins_used,
  output logic       chg_rx
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

  localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]     PRICE8   = 8'(PRICE);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  state_t          state, state_d;
  logic [3:0]      cnt5, cnt5_d;
  logic [3:0]      cnt10, cnt10_d;
  logic            mode_q, mode_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic [1:0]      coin_d;
  logic [1:0]      err_d;
  logic [6:0]      paid_d;
  logic [4:0]      used_d;
  logic            chg_rx_d;

  logic [7:0]      sum;
  logic [6:0]      paid_new;
  logic            reached;
  logic            chg_fault;

  // Coin selection for the upcoming DRIVE cycle, from the purse/paid values it will see.
  function automatic logic [1:0] pick(input logic [3:0] c5, input logic [3:0] c10,
                                      input logic m, input logic [6:0] p);
    logic [1:0] r;
    r = COIN_NONE;
    if (!m) begin
      if (c10 != 4'd0 && ({1'b0, p} + 8'd10) <= PRICE8) r = COIN_10;
      else if (c5 != 4'd0)                              r = COIN_5;
      else if (c10 != 4'd0)                             r = COIN_10;
    end else begin
      if (c5 != 4'd0)       r = COIN_5;
      else if (c10 != 4'd0) r = COIN_10;
    end
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt5       <= '0;
      cnt10      <= '0;
      mode_q     <= 1'b0;
      gap_cnt    <= '0;
      coin       <= COIN_NONE;
      err        <= 2'b00;
      paid       <= '0;
      coins_used <= '0;
      chg_rx     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt5       <= cnt5_d;
      cnt10      <= cnt10_d;
      mode_q     <= mode_d;
      gap_cnt    <= gap_d;
      coin       <= coin_d;
      err        <= err_d;
      paid       <= paid_d;
      coins_used <= used_d;
      chg_rx     <= chg_rx_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state;
    cnt5_d    = cnt5;
    cnt10_d   = cnt10;
    mode_d    = mode_q;
    gap_d     = gap_cnt;
    err_d     = err;
    paid_d    = paid;
    used_d    = coins_used;
    chg_rx_d  = chg_rx;
    sum       = {1'b0, paid} + ((coin == COIN_10) ? 8'd10 : 8'd5);
    paid_new  = (sum > 8'd127) ? 7'd127 : sum[6:0];
    reached   = ({1'b0, paid_new} >= PRICE8);
    chg_fault = 1'b0;
`ifdef COIN_PAYER_CHG_CHECK_EN
    chg_fault = chg5 && !dispense;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          cnt5_d   = n5;
          cnt10_d  = n10;
          mode_d   = mode;
          paid_d   = '0;
          used_d   = '0;
          err_d    = 2'b00;
          chg_rx_d = 1'b0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (coin == COIN_NONE) begin
          // Purse ran dry before the price was reached.
          err_d   = 2'b01;
          state_d = DONE;
        end else begin
          paid_d = paid_new;
          used_d = coins_used + 5'd1;
          if (coin == COIN_5) cnt5_d  = cnt5 - 4'd1;
          else                cnt10_d = cnt10 - 4'd1;

          if (chg_fault) begin
            err_d   = 2'b11;
            state_d = DONE;
          end else if (dispense && reached) begin
            chg_rx_d = chg5;
            err_d    = 2'b00;
`ifdef COIN_PAYER_CHG_CHECK_EN
            if (chg5 != ({1'b0, paid_new} == PRICE8 + 8'd5)) err_d = 2'b11;
`endif
            state_d  = DONE;
          end else if (dispense || reached) begin
            // Premature vend or missing vend.
            err_d   = 2'b10;
            state_d = DONE;
          end else begin
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? DRIVE : GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = DRIVE;
        else                     gap_d   = gap_cnt + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Coin register is loaded on entry to DRIVE from the values DRIVE will see.
    coin_d = (state_d == DRIVE) ? pick(cnt5_d, cnt10_d, mode_d, paid_d) : COIN_NONE;
  end

  // Status outputs.
  always_comb begin
    busy = (state == DRIVE) || (state == GAP);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_vend_coin_payer.sv
module tb_vend_coin_payer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n5 = '0;
  logic [3:0] n10 = '0;
  logic       mode = 1'b0;
  logic       dispense;
  logic       chg5;
  logic [1:0] coin;
  logic       busy, done;
  logic [1:0] err;
  logic [6:0] paid;
  logic [4:0] coins_used;
  logic       chg_rx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vend_coin_payer #(.PRICE(20), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .n5(n5), .n10(n10), .mode(mode),
    .dispense(dispense), .chg5(chg5), .coin(coin), .busy(busy), .done(done),
    .err(err), .paid(paid), .coins_used(coins_used), .chg_rx(chg_rx)
  );

  // Stub price-20 Mealy vending machine; bad_chg suppresses the change output.
  logic [7:0] stub_tot;
  logic [7:0] stub_val;
  logic [7:0] stub_sum;
  logic       stub_clr = 1'b0;
  logic       bad_chg = 1'b0;

  always_comb begin
    stub_val = (coin == 2'b01) ? 8'd5 : (coin == 2'b10) ? 8'd10 : 8'd0;
    stub_sum = stub_tot + stub_val;
    dispense = (stub_val != 8'd0) && (stub_sum >= 8'd20);
    chg5     = dispense && (stub_sum == 8'd25) && !bad_chg;
  end

  always_ff @(posedge clk) begin
    if (rst || stub_clr || dispense) stub_tot <= 8'd0;
    else                             stub_tot <= stub_sum;
  end

  // Scoreboard
  typedef struct {
    int err;
    int paid;
    int used;
    int chg;
  } res_t;

  res_t res_q[$];
  int   coin_q[$];
  logic mon_en = 1'b0;

`ifdef COIN_PAYER_CHG_CHECK_EN
  localparam int T6_ERR = 3;
`else
  localparam int T6_ERR = 0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one coin per busy cycle, one result per done pulse.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (busy) begin
        if (coin_q.size() == 0) chk("coin_unexpected", int'(coin), -1);
        else                    chk("coin", int'(coin), coin_q.pop_front());
      end
      if (done) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("err", int'(err), r.err);
          chk("paid", int'(paid), r.paid);
          chk("coins_used", int'(coins_used), r.used);
          chk("chg_rx", int'(chg_rx), r.chg);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int e, input int p, input int u, input int c);
    res_t r;
    r.err = e; r.paid = p; r.used = u; r.chg = c;
    res_q.push_back(r);
  endtask

  task automatic push_coins(input string s);
    // '1' = Rs.5, '2' = Rs.10, '0' = idle
    for (int i = 0; i < s.len(); i++) coin_q.push_back(int'(s[i]) - 48);
  endtask

  // Issue start and wait (bounded) for done; returns in IDLE.
  task automatic send(input logic [3:0] a5, input logic [3:0] a10, input logic m);
    bit seen;
    n5 = a5; n10 = a10; mode = m;
    start = 1'b1; stub_clr = 1'b1;
    tick();
    start = 1'b0; stub_clr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_coin", int'(coin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_paid", int'(paid), 0);
    chk("rst_used", int'(coins_used), 0);
    chk("rst_chg_rx", int'(chg_rx), 0);
    tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // T1: two Rs.10, vend on second
    push_coins("202");
    expect_res(0, 20, 2, 0);
    send(4'd0, 4'd2, 1'b0);

    // T2: four Rs.5 with gaps
    push_coins("1010101");
    expect_res(0, 20, 4, 0);
    send(4'd4, 4'd0, 1'b0);

    // T3: 5-first, vend at 25 with change
    push_coins("1010102");
    expect_res(0, 25, 4, 1);
    send(4'd3, 4'd1, 1'b1);

    // T4: purse runs out at 15
    push_coins("20100");
    expect_res(1, 15, 2, 0);
    send(4'd1, 4'd1, 1'b0);

    // Empty purse
    push_coins("0");
    expect_res(1, 0, 0, 0);
    send(4'd0, 4'd0, 1'b0);

    // Start during busy is ignored: hold start high through the transaction
    push_coins("202");
    expect_res(0, 20, 2, 0);
    n5 = 4'd0; n10 = 4'd2; mode = 1'b0;
    start = 1'b1; stub_clr = 1'b1;
    tick();
    stub_clr = 1'b0;
    tick();
    tick();
    start = 1'b0;
    repeat (3) tick();

    // T5: reset during the gap after the first coin
    mon_en = 1'b0;
    n5 = 4'd0; n10 = 4'd2; mode = 1'b0;
    start = 1'b1; stub_clr = 1'b1;
    tick();
    start = 1'b0; stub_clr = 1'b0;
    tick();
    chk("t5_in_gap_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_coin", int'(coin), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_paid", int'(paid), 0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    push_coins("202");
    expect_res(0, 20, 2, 0);
    send(4'd0, 4'd2, 1'b0);

    // T6: vending machine withholds change on a 25 vend
    bad_chg = 1'b1;
    push_coins("1010102");
    expect_res(T6_ERR, 25, 4, 0);
    send(4'd3, 4'd1, 1'b1);
    bad_chg = 1'b0;

    repeat (2) tick();
    chk("res_q_left", res_q.size(), 0);
    chk("coin_q_left", coin_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
